vga_ctrl: RTL and testbench
===========================

# vga_ctrl

VGA timing controller that sequences the `vga_pic` pixel generator. It produces the horizontal/vertical counters, hsync/vsync, and the `pix_x`/`pix_y` request coordinates. It drives those coordinates one cycle ahead of the visible window to cover `vga_pic`'s registered `pix_data` latency, then gates the returned pixel onto `rgb`. It sits between `vga_pic` and the board VGA pins, clocked by `vga_clk`; default timing is 640x480@60 (25 MHz pixel clock).

## Interface
Parameters:
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch
- DATA_W, 16, pixel width (RGB565)

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- disp_en  in  1  display enable; takes effect only at frame boundaries
- pix_data  in  DATA_W  pixel from `vga_pic`, valid one cycle after `pix_x`/`pix_y`
- pix_x  out  10  requested column, or 10'h3ff outside the request window
- pix_y  out  10  requested row, or 10'h3ff outside the request window
- hsync  out  1  high during the horizontal sync pulse
- vsync  out  1  high during the vertical sync pulse
- rgb_valid  out  1  high in the visible window
- rgb  out  DATA_W  `pix_data` when `rgb_valid`, else 0
- frame_start  out  1  one-cycle pulse at the first clock of each frame

## Operation
- Derived values:
  - H_TOTAL = sum of the H_* parameters (800 at defaults)
  - V_TOTAL = sum of the V_* parameters (525)
  - HS = H_SYNC+H_BACK (144)
  - VS = V_SYNC+V_BACK (35)
- Parameter constraints: H_TOTAL ≤ 1024, V_TOTAL ≤ 1024, HS ≥ 1.
- Two-state FSM, IDLE/RUN. Reset state is IDLE.
  - IDLE: cnt_h = cnt_v = 0 and held. Every output is at its reset value.
  - IDLE→RUN: disp_en=1 sampled on an edge. The next cycle is cnt_h=0, cnt_v=0 in RUN.
  - In RUN, cnt_h increments each clock and wraps H_TOTAL-1→0. cnt_v increments on each cnt_h wrap and wraps V_TOTAL-1→0.
  - RUN→IDLE: only on the last clock of a frame (cnt_h=H_TOTAL-1, cnt_v=V_TOTAL-1) with disp_en=0. Frames are never truncated.
  - A disp_en toggle mid-frame has no effect.
- Output decode, combinational from registered state and counters, all gated by RUN:
  - hsync = cnt_h < H_SYNC.
  - vsync = cnt_v < V_SYNC.
  - Request window: cnt_v in [VS, VS+V_ACTIVE-1] and cnt_h in [HS-1, HS+H_ACTIVE-2].
  - pix_x = cnt_h-(HS-1) and pix_y = cnt_v-VS inside the request window; otherwise both 10'h3ff.
  - rgb_valid: cnt_v in the same range and cnt_h in [HS, HS+H_ACTIVE-1], i.e. the request window delayed by exactly one clock.
  - rgb = rgb_valid ? pix_data : 0.
  - frame_start = RUN & cnt_h==0 & cnt_v==0.
- Arithmetic: unsigned 10-bit; the subtractions never underflow inside their windows.

## Timing
- Reset values: pix_x = pix_y = 10'h3ff; hsync, vsync, rgb_valid, frame_start = 0; rgb = 0.
- Asserting sys_rst forces IDLE and zeroes the counters immediately, mid-line or mid-frame. Outputs return to reset values without waiting for a clock edge.
- Latency: coordinate (x,y) is presented on edge N. `vga_pic` registers it, and `rgb` carries its pixel during cycle N+1 with rgb_valid=1.
- Line timing at defaults:
  - hsync high for cnt_h 0..95.
  - First request x=0 at cnt_h=143; last request x=639 at cnt_h=782.
  - rgb_valid high for cnt_h 144..783.
- Frame timing: vsync high for lines 0..1; visible lines 35..514.
- frame_start period in continuous RUN is H_TOTAL*V_TOTAL = 420000 clocks.
- Lines outside the visible range: pix_x and pix_y are both 10'h3ff for all cnt_h.

## Test plan
- Reset/idle:
  - Stimulus: hold sys_rst, then release with disp_en=0 for 1000 clocks.
  - Required: pix_x = pix_y = 3ff; hsync, vsync, rgb_valid, rgb, frame_start all 0 throughout.
- Start and line timing:
  - Stimulus: raise disp_en.
  - Required: frame_start one clock after the sampling edge. hsync high 96 clocks per 800-clock line. pix_x steps 0..639 from clock 143 of the first visible line (line 35) with pix_y=0. rgb_valid high for clocks 144..783.
- Latency alignment:
  - Stimulus: behavioural `vga_pic` model returning {pix_y[5:0], pix_x[9:0]} registered.
  - Required: every rgb sample with rgb_valid=1 equals the coordinate requested one clock earlier; x=0 and x=639 are checked on lines 0 and 479. rgb=0 whenever rgb_valid=0.
- Frame wrap:
  - Stimulus: run 2 frames.
  - Required: frame_start pulses exactly 420000 clocks apart. vsync high for 1600 clocks per frame. 480 lines carry requests per frame.
- Graceful stop:
  - Stimulus: drop disp_en at line 200.
  - Required: the frame completes through line 524 / clock 799, then the block enters IDLE with outputs at reset values. Re-raising disp_en restarts at cnt_h = cnt_v = 0.
- Async reset mid-line:
  - Stimulus: pulse sys_rst at line 100, x=300, between clock edges.
  - Required: outputs go to reset values immediately, without a clock edge. With disp_en=1 after release, a new frame starts with frame_start.

Source files
------------

// File: rtl/vga_ctrl.sv
// VGA timing controller: sequences h/v counters, syncs and pixel requests for vga_pic.
// Coordinates are requested one clock ahead of the visible window to absorb vga_pic's registered output.
module vga_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int DATA_W   = 16
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              disp_en,
  input  logic [DATA_W-1:0] pix_data,
  output logic [9:0]        pix_x,
  output logic [9:0]        pix_y,
  output logic              hsync,
  output logic              vsync,
  output logic              rgb_valid,
  output logic [DATA_W-1:0] rgb,
  output logic              frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HS      = H_SYNC + H_BACK;
  localparam int VS      = V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] REQ_H_FIRST = 10'(HS - 1);
  localparam logic [9:0] REQ_H_LAST  = 10'(HS + H_ACTIVE - 2);
  localparam logic [9:0] VAL_H_FIRST = 10'(HS);
  localparam logic [9:0] VAL_H_LAST  = 10'(HS + H_ACTIVE - 1);
  localparam logic [9:0] ROW_FIRST   = 10'(VS);
  localparam logic [9:0] ROW_LAST    = 10'(VS + V_ACTIVE - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_h_q <= '0;
      cnt_v_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  // disp_en is only honoured on the last clock of a frame, so frames never truncate.
  always_comb begin
    state_d = state_q;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    unique case (state_q)
      IDLE: begin
        cnt_h_d = '0;
        cnt_v_d = '0;
        if (disp_en) state_d = RUN;
      end
      RUN: begin
        if (cnt_h_q == H_LAST) begin
          cnt_h_d = '0;
          if (cnt_v_q == V_LAST) begin
            cnt_v_d = '0;
            if (!disp_en) state_d = IDLE;
          end else begin
            cnt_v_d = cnt_v_q + 10'd1;
          end
        end else begin
          cnt_h_d = cnt_h_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic run, row_in, req_win, val_win;

  always_comb begin
    run         = (state_q == RUN);
    row_in      = (cnt_v_q >= ROW_FIRST) && (cnt_v_q <= ROW_LAST);
    req_win     = run && row_in && (cnt_h_q >= REQ_H_FIRST) && (cnt_h_q <= REQ_H_LAST);
    val_win     = run && row_in && (cnt_h_q >= VAL_H_FIRST) && (cnt_h_q <= VAL_H_LAST);
    hsync       = run && (cnt_h_q < H_SYNC_END);
    vsync       = run && (cnt_v_q < V_SYNC_END);
    pix_x       = req_win ? (cnt_h_q - REQ_H_FIRST) : 10'h3ff;
    pix_y       = req_win ? (cnt_v_q - ROW_FIRST) : 10'h3ff;
    rgb_valid   = val_win;
    rgb         = val_win ? pix_data : '0;
    frame_start = run && (cnt_h_q == 10'd0) && (cnt_v_q == 10'd0);
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl with a shrunken 19x13 raster so several frames fit in a short run.
// Expected outputs come from a frame-time model: position t in the frame gives h = t % H_TOTAL, v = t / H_TOTAL.
module tb_vga_ctrl;

  localparam int HSY = 4, HBK = 3, HA = 10, HFR = 2;
  localparam int VSY = 2, VBK = 3, VA = 6, VFR = 2;
  localparam int HT = HSY + HBK + HA + HFR;   // 19
  localparam int VT = VSY + VBK + VA + VFR;   // 13
  localparam int HS = HSY + HBK;              // 7
  localparam int VS = VSY + VBK;              // 5
  localparam int FRAME = HT * VT;             // 247
  localparam int DW = 16;

  logic          vga_clk, sys_rst, disp_en;
  logic [DW-1:0] pix_data;
  logic [9:0]    pix_x, pix_y;
  logic          hsync, vsync, rgb_valid, frame_start;
  logic [DW-1:0] rgb;

  vga_ctrl #(
    .H_SYNC(HSY), .H_BACK(HBK), .H_ACTIVE(HA), .H_FRONT(HFR),
    .V_SYNC(VSY), .V_BACK(VBK), .V_ACTIVE(VA), .V_FRONT(VFR), .DATA_W(DW)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .disp_en(disp_en), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .rgb_valid(rgb_valid), .rgb(rgb), .frame_start(frame_start)
  );

  // ---------------- clock / reset ----------------
  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  // vga_pic stand-in: registered pixel encoding the coordinate it was asked for
  always @(posedge vga_clk) pix_data <= {pix_y[5:0], pix_x};

  // ---------------- reference model ----------------
  bit m_run = 1'b0;
  int m_t   = 0;

  always @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_run <= 1'b0;
      m_t   <= 0;
    end else if (!m_run) begin
      if (disp_en) begin
        m_run <= 1'b1;
        m_t   <= 0;
      end
    end else if (m_t == FRAME - 1) begin
      m_t <= 0;
      if (!disp_en) m_run <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  function automatic logic [23:0] pk(input bit hs, input bit vs, input bit rv, input bit fs,
                                     input logic [9:0] x, input logic [9:0] y);
    return {hs, vs, rv, fs, x, y};
  endfunction

  function automatic logic [23:0] model_out(input bit run, input int t);
    int h, v;
    bit row, req, val;
    logic [9:0] x, y;
    h   = t % HT;
    v   = t / HT;
    row = (v >= VS) && (v < VS + VA);
    req = run && row && (h >= HS - 1) && (h < HS - 1 + HA);
    val = run && row && (h >= HS) && (h < HS + HA);
    x   = req ? 10'(h - (HS - 1)) : 10'h3ff;
    y   = req ? 10'(v - VS) : 10'h3ff;
    return pk(run && (h < HSY), run && (v < VSY), val, run && (t == 0), x, y);
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge vga_clk) begin
    if (chk_en) begin
      logic [23:0] e;
      logic [DW-1:0] px;
      e = model_out(m_run, m_t);
      chk("cycle", {8'd0, hsync, vsync, rgb_valid, frame_start, pix_x, pix_y}, {8'd0, e});
      if (e[21]) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          px = exp_q.pop_front();
          chk("rgb", {16'd0, rgb}, {16'd0, px});
        end
      end else begin
        chk("rgb_zero", {16'd0, rgb}, 32'd0);
      end
      if (!m_run) exp_q.delete();
      if (e[19:10] != 10'h3ff) exp_q.push_back({e[5:0], e[19:10]});
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_fs(input string nm);
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge vga_clk);
      if (frame_start) return;
    end
    chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    int h;
    int v;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int cur, tgt, per, vs_cnt, req_lines;
    logic [9:0] nx;

    tbl[0]  = '{0,  0,  pk(1, 1, 0, 1, 10'h3ff, 10'h3ff)};
    tbl[1]  = '{3,  0,  pk(1, 1, 0, 0, 10'h3ff, 10'h3ff)};
    tbl[2]  = '{4,  0,  pk(0, 1, 0, 0, 10'h3ff, 10'h3ff)};
    tbl[3]  = '{0,  1,  pk(1, 1, 0, 0, 10'h3ff, 10'h3ff)};
    tbl[4]  = '{0,  2,  pk(1, 0, 0, 0, 10'h3ff, 10'h3ff)};
    tbl[5]  = '{5,  5,  pk(0, 0, 0, 0, 10'h3ff, 10'h3ff)};
    tbl[6]  = '{6,  5,  pk(0, 0, 0, 0, 10'd0,   10'd0)};
    tbl[7]  = '{7,  5,  pk(0, 0, 1, 0, 10'd1,   10'd0)};
    tbl[8]  = '{15, 5,  pk(0, 0, 1, 0, 10'd9,   10'd0)};
    tbl[9]  = '{16, 5,  pk(0, 0, 1, 0, 10'h3ff, 10'h3ff)};
    tbl[10] = '{17, 5,  pk(0, 0, 0, 0, 10'h3ff, 10'h3ff)};
    tbl[11] = '{6,  10, pk(0, 0, 0, 0, 10'd0,   10'd5)};
    tbl[12] = '{16, 10, pk(0, 0, 1, 0, 10'h3ff, 10'h3ff)};
    tbl[13] = '{6,  11, pk(0, 0, 0, 0, 10'h3ff, 10'h3ff)};
    tbl[14] = '{18, 12, pk(0, 0, 0, 0, 10'h3ff, 10'h3ff)};

    // reset and long idle
    sys_rst = 1'b1;
    disp_en = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge vga_clk);
    #2 sys_rst = 1'b0;
    repeat (1000) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("idle", {8'd0, hsync, vsync, rgb_valid, frame_start, pix_x, pix_y},
        {8'd0, pk(0, 0, 0, 0, 10'h3ff, 10'h3ff)});

    // start: the edge after disp_en rises is the sampling edge, then t = 0
    @(posedge vga_clk);
    #2 disp_en = 1'b1;
    @(posedge vga_clk);
    cur = 0;
    for (int i = 0; i < 15; i++) begin
      tgt = tbl[i].v * HT + tbl[i].h;
      repeat (tgt - cur) @(posedge vga_clk);
      cur = tgt;
      @(negedge vga_clk);
      chk($sformatf("tbl%0d", i), {8'd0, hsync, vsync, rgb_valid, frame_start, pix_x, pix_y},
          {8'd0, tbl[i].exp});
    end

    // two full frames: period, vsync width, lines carrying requests
    wait_fs("fs_first");
    for (int f = 0; f < 2; f++) begin
      per       = 0;
      vs_cnt    = vsync ? 1 : 0;
      req_lines = (pix_x == 10'd0) ? 1 : 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
        @(negedge vga_clk);
        per++;
        if (frame_start) break;
        if (vsync) vs_cnt++;
        if (pix_x == 10'd0) req_lines++;
      end
      chk("fs_period", per, FRAME);
      chk("vsync_clocks", vs_cnt, VSY * HT);
      chk("req_lines", req_lines, VA);
    end

    // graceful stop: drop disp_en on line 8, frame must still complete
    repeat (8 * HT) @(posedge vga_clk);
    #2 disp_en = 1'b0;
    repeat (FRAME - 1 - 8 * HT) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("last_clk_hsync", {31'd0, hsync}, 32'd0);
    @(posedge vga_clk);
    for (int k = 0; k < 50; k++) begin
      @(negedge vga_clk);
      chk("stopped", {8'd0, hsync, vsync, rgb_valid, frame_start, pix_x, pix_y},
          {8'd0, pk(0, 0, 0, 0, 10'h3ff, 10'h3ff)});
    end
    @(posedge vga_clk);
    #2 disp_en = 1'b1;
    @(posedge vga_clk);
    @(negedge vga_clk);
    chk("restart_fs", {30'd0, frame_start, hsync}, 32'd3);

    // async reset on line 7, h = 10 (x = 4), between edges
    repeat (7 * HT + 10) @(posedge vga_clk);
    #2;
    nx = 10'(10 - (HS - 1));
    chk("pre_rst_x", {22'd0, pix_x}, {22'd0, nx});
    sys_rst = 1'b1;
    #1;
    chk("async_rst", {8'd0, hsync, vsync, rgb_valid, frame_start, pix_x, pix_y},
        {8'd0, pk(0, 0, 0, 0, 10'h3ff, 10'h3ff)});
    chk("async_rst_rgb", {16'd0, rgb}, 32'd0);
    repeat (2) @(posedge vga_clk);
    #2 sys_rst = 1'b0;
    @(posedge vga_clk);
    @(negedge vga_clk);
    chk("post_rst_fs", {31'd0, frame_start}, 32'd1);

    // random disp_en toggling with rare async reset pulses
    for (int i = 0; i < 4000; i++) begin
      @(posedge vga_clk);
      #2;
      if ($urandom_range(0, 99) < 3) disp_en = ~disp_en;
      if ($urandom_range(0, 699) == 0) begin
        sys_rst = 1'b1;
        #1 sys_rst = 1'b0;
      end
    end

    @(negedge vga_clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
